// File: rtl/dram_responder.sv
// Single-bank DRAM device model: decodes raw RAS/CAS/WE pins, keeps one open row,
// applies byte-masked writes and returns reads after CAS_LAT cycles with a sticky error flag.
module dram_responder #(
  parameter int ROW_BITS = 11,
  parameter int COL_BITS = 10,
  parameter int CAS_LAT  = 5,
  parameter int T_RCD    = 2,
  parameter int T_RP     = 2
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        DRAM_CSn,
  input  logic        DRAM_RASn,
  input  logic        DRAM_CASn,
  input  logic [3:0]  DRAM_WEn,
  input  logic [10:0] DRAM_A,
  input  logic [31:0] DRAM_D,
  output logic        DRAM_valid,
  output logic [31:0] DRAM_Q,
  output logic        DRAM_err,
  output logic        o_dbg_state
);

  localparam int ADDR_W = ROW_BITS + COL_BITS;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [7:0] RCD_C = 8'(T_RCD);
  localparam logic [7:0] RP_C  = 8'(T_RP);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ROW_BITS-1:0] r_row;
  logic [7:0]          r_cnt;
  logic                r_err;
  logic [CAS_LAT-1:0]  r_vld;
  logic [31:0]         r_dat [CAS_LAT];
  logic [31:0]         r_mem [DEPTH];

  logic w_sel, w_act_enc, w_pre_enc, w_rd_enc, w_wr_enc, w_ill_enc;
  logic w_do_act, w_do_pre, w_do_rd, w_do_wr, w_viol;
  logic w_rcd_ok, w_rp_ok;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_rd_word;
  logic              w_unused_a;

  // Upper address bits beyond the row/column width are intentionally ignored.
  assign w_unused_a = ^DRAM_A;

  assign w_sel     = ~DRAM_CSn;
  assign w_act_enc = w_sel & ~DRAM_RASn &  DRAM_CASn & (DRAM_WEn == 4'hF);
  assign w_pre_enc = w_sel & ~DRAM_RASn &  DRAM_CASn & (DRAM_WEn == 4'h0);
  assign w_rd_enc  = w_sel &  DRAM_RASn & ~DRAM_CASn & (DRAM_WEn == 4'hF);
  assign w_wr_enc  = w_sel &  DRAM_RASn & ~DRAM_CASn & (DRAM_WEn != 4'hF);
  assign w_ill_enc = w_sel & ~DRAM_RASn &
                     (~DRAM_CASn | ((DRAM_WEn != 4'hF) & (DRAM_WEn != 4'h0)));

  assign w_rcd_ok  = (r_cnt >= RCD_C);
  assign w_rp_ok   = (r_cnt >= RP_C);
  assign w_addr    = {r_row, DRAM_A[COL_BITS-1:0]};
  assign w_rd_word = r_mem[w_addr];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Any violation drops the command entirely; only the error flag records it.
  always_comb begin
    w_state_nxt = r_state;
    w_do_act    = 1'b0;
    w_do_pre    = 1'b0;
    w_do_rd     = 1'b0;
    w_do_wr     = 1'b0;
    w_viol      = w_ill_enc;
    case (r_state)
      ST_IDLE: begin
        if (w_act_enc) begin
          if (w_rp_ok) begin
            w_do_act    = 1'b1;
            w_state_nxt = ST_ACTIVE;
          end else begin
            w_viol = 1'b1;
          end
        end
        if (w_pre_enc)            w_do_pre = 1'b1;
        if (w_rd_enc || w_wr_enc) w_viol   = 1'b1;
      end
      ST_ACTIVE: begin
        if (w_act_enc) w_viol = 1'b1;
        if (w_pre_enc) begin
          w_do_pre    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        if (w_rd_enc) begin
          if (w_rcd_ok) w_do_rd = 1'b1;
          else          w_viol  = 1'b1;
        end
        if (w_wr_enc) begin
          if (w_rcd_ok) w_do_wr = 1'b1;
          else          w_viol  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counter restarts at 1 on the edge after ACT/PRE, so the command edge itself counts as 0.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_row <= '0;
      r_cnt <= 8'hFF;
      r_err <= 1'b0;
    end else begin
      if (w_do_act) r_row <= DRAM_A[ROW_BITS-1:0];
      if (w_do_act || w_do_pre) r_cnt <= 8'd1;
      else if (r_cnt != 8'hFF)  r_cnt <= r_cnt + 8'd1;
      if (w_viol) r_err <= 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_do_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (!DRAM_WEn[i]) r_mem[w_addr][8*i +: 8] <= DRAM_D[8*i +: 8];
      end
    end
  end

  // Data is captured at issue, so later writes never disturb reads in flight.
  // Idle stages hold zero so DRAM_Q is zero whenever DRAM_valid is low.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_vld <= '0;
      for (int i = 0; i < CAS_LAT; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= w_do_rd;
      r_dat[0] <= w_do_rd ? w_rd_word : 32'h0;
      for (int i = 1; i < CAS_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign DRAM_valid  = r_vld[CAS_LAT-1];
  assign DRAM_Q      = r_dat[CAS_LAT-1];
  assign DRAM_err    = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: commands are driven at the falling edge,
// outputs sampled at the falling edge; "pos" counts falling edges after a READ edge.
module tb_dram_responder;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        DRAM_CSn;
  logic        DRAM_RASn;
  logic        DRAM_CASn;
  logic [3:0]  DRAM_WEn;
  logic [10:0] DRAM_A;
  logic [31:0] DRAM_D;
  logic        DRAM_valid;
  logic [31:0] DRAM_Q;
  logic        DRAM_err;
  logic        dbg_state;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 ACLK = ~ACLK;

  dram_responder dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .DRAM_CSn    (DRAM_CSn),
    .DRAM_RASn   (DRAM_RASn),
    .DRAM_CASn   (DRAM_CASn),
    .DRAM_WEn    (DRAM_WEn),
    .DRAM_A      (DRAM_A),
    .DRAM_D      (DRAM_D),
    .DRAM_valid  (DRAM_valid),
    .DRAM_Q      (DRAM_Q),
    .DRAM_err    (DRAM_err),
    .o_dbg_state (dbg_state)
  );

  task automatic tick();
    @(negedge ACLK);
  endtask

  task automatic nop();
    DRAM_CSn  = 1'b1;
    DRAM_RASn = 1'b1;
    DRAM_CASn = 1'b1;
    DRAM_WEn  = 4'hF;
    DRAM_A    = '0;
    DRAM_D    = '0;
  endtask

  task automatic send(input logic rasn, input logic casn, input logic [3:0] wen,
                      input logic [10:0] a, input logic [31:0] d);
    DRAM_CSn  = 1'b0;
    DRAM_RASn = rasn;
    DRAM_CASn = casn;
    DRAM_WEn  = wen;
    DRAM_A    = a;
    DRAM_D    = d;
    tick();
    nop();
  endtask

  task automatic act(input logic [10:0] row);
    send(1'b0, 1'b1, 4'hF, row, 32'h0);
  endtask

  task automatic pre();
    send(1'b0, 1'b1, 4'h0, 11'h0, 32'h0);
  endtask

  task automatic rd(input logic [10:0] col);
    send(1'b1, 1'b0, 4'hF, col, 32'h0);
  endtask

  task automatic wr(input logic [10:0] col, input logic [31:0] d, input logic [3:0] wen);
    send(1'b1, 1'b0, wen, col, d);
  endtask

  task automatic do_reset();
    nop();
    ARESETn = 1'b0;
    tick();
    tick();
    ARESETn = 1'b1;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Expects exactly one valid beat at pos 4 (CAS_LAT-1 falling edges after the READ edge).
  task automatic check_read(input string tag, input logic [31:0] exp, input int start_pos);
    for (int p = start_pos; p < 4; p++) begin
      chk({tag, "_early_valid"}, 32'(DRAM_valid), 32'h0);
      tick();
    end
    chk({tag, "_valid"}, 32'(DRAM_valid), 32'h1);
    chk({tag, "_data"}, DRAM_Q, exp);
    tick();
    chk({tag, "_late_valid"}, 32'(DRAM_valid), 32'h0);
    chk({tag, "_late_q"}, DRAM_Q, 32'h0);
  endtask

  task automatic check_silent(input string tag, input int cycles);
    for (int p = 0; p < cycles; p++) begin
      chk({tag, "_valid"}, 32'(DRAM_valid), 32'h0);
      chk({tag, "_q"}, DRAM_Q, 32'h0);
      tick();
    end
  endtask

  initial begin
    nop();
    ARESETn = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(DRAM_valid), 32'h0);
    chk("rst_q", DRAM_Q, 32'h0);
    chk("rst_err", 32'(DRAM_err), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);
    ARESETn = 1'b1;
    tick();

    // Basic write/read with full tRCD wait.
    act(11'h005);
    chk("act_state", 32'(dbg_state), 32'h1);
    tick();
    wr(11'h010, 32'hDEADBEEF, 4'h0);
    rd(11'h010);
    check_read("basic", 32'hDEADBEEF, 0);
    chk("basic_err", 32'(DRAM_err), 32'h0);

    // Byte mask.
    wr(11'h020, 32'h11223344, 4'h0);
    wr(11'h020, 32'hAABBCCDD, 4'b1010);
    rd(11'h020);
    check_read("mask", 32'h11BB33DD, 0);

    // Back-to-back reads followed by a write to a word still in flight.
    wr(11'h000, 32'h0, 4'h0);
    wr(11'h001, 32'h1, 4'h0);
    wr(11'h002, 32'h2, 4'h0);
    wr(11'h003, 32'h3, 4'h0);
    rd(11'h000);
    rd(11'h001);
    rd(11'h002);
    rd(11'h003);
    chk("b2b_pos3_valid", 32'(DRAM_valid), 32'h0);
    wr(11'h000, 32'hFFFFFFFF, 4'h0);
    chk("b2b0_valid", 32'(DRAM_valid), 32'h1);
    chk("b2b0_data", DRAM_Q, 32'h0);
    tick();
    chk("b2b1_valid", 32'(DRAM_valid), 32'h1);
    chk("b2b1_data", DRAM_Q, 32'h1);
    tick();
    chk("b2b2_valid", 32'(DRAM_valid), 32'h1);
    chk("b2b2_data", DRAM_Q, 32'h2);
    tick();
    chk("b2b3_valid", 32'(DRAM_valid), 32'h1);
    chk("b2b3_data", DRAM_Q, 32'h3);
    tick();
    chk("b2b_end_valid", 32'(DRAM_valid), 32'h0);
    rd(11'h000);
    check_read("after_wr", 32'hFFFFFFFF, 0);
    chk("b2b_err", 32'(DRAM_err), 32'h0);

    // PRE with a read in flight: data still returns, row closes.
    rd(11'h020);
    pre();
    check_read("pre_inflight", 32'h11BB33DD, 1);
    chk("pre_inflight_err", 32'(DRAM_err), 32'h0);
    chk("pre_inflight_state", 32'(dbg_state), 32'h0);

    // Violation: READ one cycle after ACT.
    do_reset();
    act(11'h001);
    chk("v_rcd_err_before", 32'(DRAM_err), 32'h0);
    rd(11'h000);
    chk("v_rcd_err", 32'(DRAM_err), 32'h1);
    check_silent("v_rcd_drop", 7);
    chk("v_rcd_sticky", 32'(DRAM_err), 32'h1);

    // Violation: READ with no open row.
    do_reset();
    chk("v_idle_err_before", 32'(DRAM_err), 32'h0);
    rd(11'h000);
    chk("v_idle_err", 32'(DRAM_err), 32'h1);
    check_silent("v_idle_drop", 6);

    // Violation: ACT while ACTIVE.
    do_reset();
    act(11'h001);
    tick();
    tick();
    chk("v_act_err_before", 32'(DRAM_err), 32'h0);
    act(11'h002);
    chk("v_act_err", 32'(DRAM_err), 32'h1);
    chk("v_act_state", 32'(dbg_state), 32'h1);

    // Violation: illegal encoding RASn=CASn=0.
    do_reset();
    send(1'b0, 1'b0, 4'hF, 11'h0, 32'h0);
    chk("v_ill_err", 32'(DRAM_err), 32'h1);
    chk("v_ill_state", 32'(dbg_state), 32'h0);
    tick();
    tick();
    chk("v_ill_sticky", 32'(DRAM_err), 32'h1);

    // Violation: ACT one cycle after PRE.
    do_reset();
    pre();
    chk("v_rp_err_before", 32'(DRAM_err), 32'h0);
    act(11'h003);
    chk("v_rp_err", 32'(DRAM_err), 32'h1);
    chk("v_rp_state", 32'(dbg_state), 32'h0);

    // Legal row switch: PRE then ACT exactly tRP later, read from the new row.
    do_reset();
    act(11'h009);
    tick();
    wr(11'h010, 32'h99999999, 4'h0);
    pre();
    tick();
    act(11'h005);
    chk("sw_err", 32'(DRAM_err), 32'h0);
    chk("sw_state", 32'(dbg_state), 32'h1);
    tick();
    rd(11'h010);
    check_read("sw_read", 32'hDEADBEEF, 0);
    chk("sw_err_after", 32'(DRAM_err), 32'h0);

    // Reset mid-read flushes the pipeline; array survives.
    rd(11'h020);
    tick();
    ARESETn = 1'b0;
    tick();
    tick();
    ARESETn = 1'b1;
    check_silent("rst_flush", 8);
    chk("rst_flush_state", 32'(dbg_state), 32'h0);
    chk("rst_flush_err", 32'(DRAM_err), 32'h0);
    act(11'h005);
    tick();
    rd(11'h010);
    check_read("keep_a", 32'hDEADBEEF, 0);
    rd(11'h020);
    check_read("keep_b", 32'h11BB33DD, 0);
    rd(11'h000);
    check_read("keep_c", 32'hFFFFFFFF, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dram_responder.md
# dram_responder

Cycle-accurate single-bank DRAM device that answers the raw command pins driven by the DRAM controller wrapper: it decodes RAS/CAS/WE commands, keeps one open row, writes byte-masked data and returns read data after a fixed CAS latency with a one-cycle `DRAM_valid` strobe. It sits outside `top`, on the far side of the DRAM pins. It is the responder for the DRAM wrapper in system simulation and the golden device in wrapper-level benches. A sticky protocol-error flag exposes timing and command violations to the bench.

## Interface
- `ROW_BITS`, 11, row address width, taken from `DRAM_A[ROW_BITS-1:0]` on ACT.
- `COL_BITS`, 10, column address width, taken from `DRAM_A[COL_BITS-1:0]` on READ/WRITE; must be ≤ 11.
- `CAS_LAT`, 5, cycles from READ sample edge to data edge; must be ≥ 1.
- `T_RCD`, 2, minimum cycles from ACT to READ/WRITE.
- `T_RP`, 2, minimum cycles from PRE to ACT.

- `ACLK`  in  1  clock; all sampling on rising edge.
- `ARESETn`  in  1  asynchronous active-low reset.
- `DRAM_CSn`  in  1  chip select, active low; high means NOP.
- `DRAM_RASn`  in  1  row strobe, active low.
- `DRAM_CASn`  in  1  column strobe, active low.
- `DRAM_WEn`  in  4  per-byte write enable, active low.
- `DRAM_A`  in  11  multiplexed row/column address.
- `DRAM_D`  in  32  write data.
- `DRAM_valid`  out  1  read data strobe, one cycle per READ.
- `DRAM_Q`  out  32  read data; 0 whenever `DRAM_valid`=0.
- `DRAM_err`  out  1  sticky protocol violation flag.

## Operation
- Storage: 2^(ROW_BITS+COL_BITS) × 32-bit array, indexed {row, col}. Reset does not clear the array.
- Command decode, evaluated at a rising edge only when `DRAM_CSn`=0:
  - RASn=0, CASn=1, WEn=4'hF: ACT. Opens row `A[ROW_BITS-1:0]`.
  - RASn=0, CASn=1, WEn=4'h0: PRE. Closes the open row.
  - RASn=1, CASn=0, WEn=4'hF: READ from column `A[COL_BITS-1:0]` of the open row.
  - RASn=1, CASn=0, WEn≠4'hF: WRITE. Byte i gets `DRAM_D[8i+7:8i]` where `WEn[i]`=0; other bytes are kept.
  - RASn=1, CASn=1: NOP.
  - Any other encoding is illegal.
- State machine:
  - States are IDLE (no row open) and ACTIVE (row register valid).
  - IDLE→ACTIVE on a legal ACT; ACTIVE→IDLE on PRE.
  - PRE in IDLE is a legal no-op and does restart the tRP count.
- Violations:
  - Cases: ACT while ACTIVE; ACT earlier than T_RP after PRE; READ/WRITE in IDLE; READ/WRITE earlier than T_RCD after ACT; illegal encoding.
  - Each violation sets `DRAM_err`=1, which stays set until reset.
  - The offending command is dropped: no state, array or pipeline change.
- Read pipeline:
  - CAS_LAT-deep shift register of {valid, data}.
  - A READ loads the array word at issue time, so a later WRITE does not alter data already in flight.
  - One READ per cycle is allowed, so up to CAS_LAT reads can be outstanding. Back-to-back reads give back-to-back `DRAM_valid` cycles.
- Timing counter:
  - Saturating counter of cycles since the last ACT or PRE.
  - Legal when count ≥ T_RCD (READ/WRITE) or ≥ T_RP (ACT). The command edge counts as 0.
- Out-of-range `DRAM_A` bits above ROW_BITS/COL_BITS are ignored.

## Timing
- Reset values:
  - Outputs: `DRAM_valid`=0, `DRAM_Q`=0, `DRAM_err`=0.
  - Internal: state IDLE, pipeline empty, timing counter saturated, so the first ACT is legal immediately.
- Reset asserted mid-operation flushes all in-flight reads and closes the row. No `DRAM_valid` appears after reset deasserts.
- READ sampled at edge t → `DRAM_valid`=1 and `DRAM_Q`=data for exactly the cycle after edge t+CAS_LAT−1, i.e. registered at edge t+CAS_LAT−1 and visible until edge t+CAS_LAT.
- WRITE sampled at edge t updates the array at edge t. A READ at edge t+1 to the same address returns the new data.
- ACT at edge t: earliest legal READ/WRITE is at edge t+T_RCD. PRE at edge t: earliest legal ACT is at edge t+T_RP.
- PRE issued while reads are in flight is legal; in-flight data still returns.
- Write data and command pins are used only at the sampling edge. Values between edges are don't-care.

## Test plan
- Reset, ACT row 0x005, wait 2, WRITE col 0x010 D=0xDEADBEEF WEn=0, READ col 0x010 → `DRAM_valid` pulse once, 5 cycles after the READ edge, with `DRAM_Q`=0xDEADBEEF; `DRAM_err`=0.
- Byte mask: pre-write 0x11223344, WRITE D=0xAABBCCDD WEn=4'b1010, READ → `DRAM_Q`=0x11BB33DD.
- Four back-to-back READs of cols 0–3 holding 0x0–0x3 → four consecutive `DRAM_valid` cycles, data 0,1,2,3 in order. A WRITE to col 0 issued right after the reads does not change the first returned word.
- Violations (reset between each): READ 1 cycle after ACT; ACT while ACTIVE; RASn=CASn=0 → `DRAM_err` rises the cycle after the command and stays high; the dropped READ produces no `DRAM_valid`.
- PRE, ACT 1 cycle later → `DRAM_err`=1. Separately: PRE, ACT 2 cycles later on a different row, READ → data from the new row; `DRAM_err`=0.
- Assert `ARESETn` low 2 cycles after a READ, release → no `DRAM_valid` ever appears, `DRAM_Q`=0, array contents from before the reset are still readable.
